// File: rtl/mux_scan_serializer.sv
// Sequencer for an external 8:1 data-select stage. It loads a byte and steps
// the select through 0..7, reassembling the byte from the true output and
// flagging any step where the complement output fails to be the inverse.
module mux_scan_serializer #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       mux_e,
  output logic [2:0] mux_s,
  output logic [7:0] mux_i,
  input  logic       mux_y,
  input  logic       mux_yn,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state_q, state_d;
  logic       mux_e_q, mux_e_d;
  logic [2:0] mux_s_q, mux_s_d;
  logic [7:0] mux_i_q, mux_i_d;
  logic [7:0] data_out_q, data_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mux_e_q    <= 1'b1;
      mux_s_q    <= '0;
      mux_i_q    <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mux_e_q    <= mux_e_d;
      mux_s_q    <= mux_s_d;
      mux_i_q    <= mux_i_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mux_e_d    = mux_e_q;
    mux_s_d    = mux_s_q;
    mux_i_d    = mux_i_q;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mux_i_d = data_in;
          mux_s_d = '0;
          mux_e_d = 1'b0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == HOLD_M1) begin
          // Select has been stable for HOLD full cycles, so sampling here is safe.
          data_out_d[mux_s_q] = mux_y;
          if (mux_y == mux_yn) err_d = 1'b1;
          cnt_d = '0;
          if (mux_s_q == 3'd7) begin
            state_d = IDLE;
            mux_e_d = 1'b1;
            mux_s_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            mux_s_d = mux_s_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mux_e    = mux_e_q;
  assign mux_s    = mux_s_q;
  assign mux_i    = mux_i_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Sequencer that drives an external 8:1 data-select stage (enable active-high-disables, 3-bit select, 8 data inputs, true and complement outputs).
- Loads a byte, enables the mux, steps the select 0..7, samples the true/complement outputs at each step and reassembles the byte.
- Also checks that the complement output is always the inverse of the true output.
- Sits between the bus-side register logic and the mux. It is both the mux's upstream stimulus and its downstream consumer.

Parameters:
- HOLD, 1, clock cycles each select value is held before sampling; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a scan; sampled only in IDLE
- data_in  input  8  byte to serialise; latched on accepted start
- mux_e  output  1  mux enable; 1 = mux disabled (output forced 0), 0 = enabled
- mux_s  output  3  mux select
- mux_i  output  8  mux data inputs, the latched byte
- mux_y  input  1  mux true output
- mux_yn  input  1  mux complement output
- data_out  output  8  reassembled byte
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse when data_out is valid
- err  output  1  complement-check failure flag for the last scan

Behaviour:
- Reset (async on rst_n low, all registered): mux_e=1, mux_s=0, mux_i=0, data_out=0, busy=0, done=0, err=0, hold counter=0, state=IDLE.
- States are IDLE and SCAN. done is a registered pulse and is not a separate state.
- IDLE:
  - mux_e=1; busy=0.
  - On an edge with start=1: mux_i<=data_in, mux_s<=0, mux_e<=0, busy<=1, err<=0, hold counter<=0, state<=SCAN.
  - data_out is not cleared on start; it holds the previous result until overwritten bit by bit.
- SCAN:
  - The hold counter counts 0..HOLD-1 on each edge.
  - On the edge where counter==HOLD-1, sample: data_out[mux_s]<=mux_y.
  - On the same edge, if mux_y==mux_yn then err<=1. err is sticky until the next accepted start.
  - The counter then resets to 0 and mux_s increments.
- On the sampling edge with mux_s==7: state<=IDLE, mux_e<=1, mux_s<=0, busy<=0, done<=1. done clears on the following edge.
- Latency: start accepted at edge N; samples occur at edges N+k*HOLD for k=1..8; done is high in the cycle after edge N+8*HOLD; busy is high for exactly 8*HOLD cycles.
- The mux is combinational. mux_s and mux_i are stable for at least HOLD full cycles before each sample, so there is no same-edge sampling of a changing select.
- start while busy=1: ignored, with no effect on mux_i, the counter or err.
- start high in the done cycle: accepted, since the state is IDLE. Back-to-back scans have one idle cycle between them.
- start held high continuously: a new scan begins every 8*HOLD+1 cycles.
- mux_s wraps only via the explicit return to 0 at scan end; there is no 7->0 increment inside SCAN.
- Reset mid-scan: immediate return to reset values, no done pulse, partial data_out discarded (cleared to 0).
- data_in changes during a scan have no effect; only mux_i drives the mux.

Test Plan:
1. Assert rst_n=0 with clk running -> mux_e=1, mux_s=0, mux_i=0, data_out=0, busy=0, done=0, err=0; hold all values after release with start=0 for 5 cycles.
2. HOLD=1, behavioural 8:1 mux model (y = i[s] when enabled, yn = ~y) connected, start pulse with data_in=0xA5 -> mux_s steps 0..7 on consecutive cycles, busy high 8 cycles, done pulse one cycle later, data_out=0xA5, err=0.
3. HOLD=3, data_in=0x3C -> each mux_s value held 3 cycles, busy high 24 cycles, data_out=0x3C, err=0; then data_in=0xFF -> 0xFF.
4. During a 0x5A scan, pulse start with data_in=0x00 at mux_s=3 -> ignored, result 0x5A, mux_i stays 0x5A; start held high through done -> second scan begins in the done cycle's next edge.
5. Fault injection: force mux_yn=mux_y while mux_s=2 only, data 0x81 -> data_out=0x81, err=1 after done; next scan clean -> err=0.
6. Reset mid-scan: rst_n low when mux_s=4 on a 0xC3 scan -> all outputs at reset values immediately, no done pulse; new start with 0x0F -> data_out=0x0F, done after 8*HOLD+1 cycles.
